mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, regardless of clk).
REQ-003 SHALL have port multstartE  input  1  start request from the controller's Execute stage.
REQ-004 SHALL have port multsignE  input  1  1=signed (mult), 0=unsigned (multu).
REQ-005 SHALL have port srcaE  input  32  multiplicand (rs value in Execute).
REQ-006 SHALL have port srcbE  input  32  multiplier (rt value in Execute).
REQ-007 SHALL have port lohiM  input  1  read select from the Memory stage: 1=HI, 0=LO.
REQ-008 SHALL have port multresM  output  32  combinational HI or LO per lohiM.
REQ-009 SHALL have port multbusy  output  1  operation in progress; the hazard unit stalls mfhi/mflo/mult on it.
REQ-010 SHALL have port multdone  output  1  one-cycle pulse after HI/LO are updated.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX.
REQ-012 IDLE with multstartE=1 at an edge SHALL latch |srcaE|, |srcbE| (magnitude only if multsignE=1, raw otherwise), latch neg=multsignE&(srcaE[31]^srcbE[31]), clear the 64-bit accumulator and count, and enter RUN.
REQ-013 RUN SHALL perform one shift-add step per edge (1 multiplier bit per step), increment count, and enter FIX after step 32.
REQ-014 FIX SHALL write {HI,LO} = neg ? two's-complement negation of the accumulator : the accumulator, pulse multdone for the following cycle, and return to IDLE.
REQ-015 Latency: start sampled at edge 0; HI/LO written at edge 33; multdone=1 during the cycle after edge 33.
REQ-016 multbusy SHALL be 1 in every cycle where state != IDLE (cycles after edges 0..32), and 0 otherwise.
REQ-017 multstartE SHALL be ignored while multbusy=1; no queuing.
REQ-018 multstartE asserted in the same cycle as the multdone pulse (state IDLE) SHALL start a new operation.
REQ-019 HI/LO SHALL hold their previous values until FIX; reads during busy return the old HI/LO.
REQ-020 Magnitude of 0x80000000 SHALL be 0x80000000 treated as unsigned 32-bit (no overflow).
REQ-021 multresM SHALL be HI when lohiM=1 and LO when lohiM=0, with no register stage.

Reset
REQ-022 rst=0 SHALL force state=IDLE, HI=0, LO=0, accumulator=0, count=0, neg=0, multbusy=0, multdone=0.
REQ-023 rst=0 mid-operation SHALL abort the operation; HI/LO SHALL be 0, and a start on the first edge after release SHALL be accepted.
REQ-024 When rst=0 and multstartE=1 coincide, reset SHALL win.

Configuration
REQ-025 With macro MULT_RADIX4_EN defined, RUN SHALL retire 2 multiplier bits per edge (16 steps); HI/LO are written at edge 17, and multbusy is high after edges 0..16.
REQ-026 Without MULT_RADIX4_EN, REQ-013/REQ-015 timing (32 steps, write at edge 33) SHALL apply.
REQ-027 Results SHALL be bit-identical in both configurations.

Verification
REQ-028 Unsigned: srcaE=0xFFFFFFFF, srcbE=0xFFFFFFFF, multsignE=0 -> HI=0xFFFFFFFE, LO=0x00000001; multdone after edge 33 (17 with radix-4).
REQ-029 Signed: srcaE=0xFFFFFFFD (-3), srcbE=0x00000007, multsignE=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-030 Signed corner: srcaE=srcbE=0x80000000, multsignE=1 -> HI=0x40000000, LO=0x00000000; the same operands with multsignE=0 -> HI=0x40000000, LO=0x00000000.
REQ-031 Busy: second multstartE (srcaE=2, srcbE=3) at edge 5 of a running op -> ignored; first result intact; lohiM=1/0 during busy returns the old HI/LO.
REQ-032 Reset mid-op: rst=0 at edge 10 of 0x80000000*2 unsigned -> HI=LO=0, multbusy=0; after release, the rerun gives HI=1, LO=0.
REQ-033 Back-to-back: multstartE held high across multdone -> second op starts in the multdone cycle, and multbusy is low for exactly that one cycle.

Source files
------------

// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add 32x32 multiplier with HI/LO result registers.
// Signed operands go through the datapath as magnitudes and the sign is
// restored after the last step, so one datapath serves both mult and multu.
// Define MULT_RADIX4_EN to retire two multiplier bits per step (16 steps)
// instead of one bit per step (32 steps). Both builds give identical results.
`timescale 1ns/1ps
module mult_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        multstartE,
  input  logic        multsignE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        lohiM,
  output logic [31:0] multresM,
  output logic        multbusy,
  output logic        multdone
);

`ifdef MULT_RADIX4_EN
  localparam int BitsPerStep = 2;
`else
  localparam int BitsPerStep = 1;
`endif
  localparam int NumSteps = 32 / BitsPerStep;
  localparam logic [5:0] LastStep = 6'(NumSteps - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT       stateReg, stateNext;
  logic [63:0] accReg;
  logic [63:0] mcandReg;
  logic [31:0] mplierReg;
  logic [5:0]  countReg;
  logic        negReg;
  logic [31:0] hiReg, loReg;
  logic        doneReg;

  logic [31:0] magA, magB;
  logic [63:0] partial [BitsPerStep];
  logic [63:0] accNext;
  logic [63:0] fixResult;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign magA = (multsignE && srcaE[31]) ? (~srcaE + 32'd1) : srcaE;
  assign magB = (multsignE && srcbE[31]) ? (~srcbE + 32'd1) : srcbE;

  // One partial product per multiplier bit retired this step.
  genvar gi;
  generate
    for (gi = 0; gi < BitsPerStep; gi++) begin : gPartial
      assign partial[gi] = mplierReg[gi] ? (mcandReg << gi) : 64'd0;
    end
  endgenerate

  // Accumulate all partial products of the current step.
  always_comb begin
    accNext = accReg;
    for (int i = 0; i < BitsPerStep; i++) begin
      accNext = accNext + partial[i];
    end
  end

  assign fixResult = negReg ? (~accReg + 64'd1) : accReg;

  // Next-state logic and status outputs.
  always_comb begin
    stateNext = stateReg;
    multbusy  = (stateReg != IDLE);
    case (stateReg)
      IDLE:    if (multstartE) stateNext = RUN;
      RUN:     if (countReg == LastStep) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  // Datapath: operand capture, shift-add steps, sign fix-up and HI/LO write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accReg    <= 64'd0;
      mcandReg  <= 64'd0;
      mplierReg <= 32'd0;
      countReg  <= 6'd0;
      negReg    <= 1'b0;
      hiReg     <= 32'd0;
      loReg     <= 32'd0;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (multstartE) begin
            mcandReg  <= {32'd0, magA};
            mplierReg <= magB;
            negReg    <= multsignE & (srcaE[31] ^ srcbE[31]);
            accReg    <= 64'd0;
            countReg  <= 6'd0;
          end
        end
        RUN: begin
          accReg    <= accNext;
          mcandReg  <= mcandReg << BitsPerStep;
          mplierReg <= mplierReg >> BitsPerStep;
          countReg  <= countReg + 6'd1;
        end
        FIX: begin
          hiReg   <= fixResult[63:32];
          loReg   <= fixResult[31:0];
          doneReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign multdone = doneReg;
  assign multresM = lohiM ? hiReg : loReg;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: vector table plus hand-written corner sequences for mult_unit,
// with a queue of expected {HI,LO} results.
`timescale 1ns/1ps
module tb_mult_unit;

`ifdef MULT_RADIX4_EN
  localparam int Lat = 17;
`else
  localparam int Lat = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        multstartE, multsignE, lohiM;
  logic [31:0] srcaE, srcbE, multresM;
  logic        multbusy, multdone;

  mult_unit dut (
    .clk(clk), .rst(rst), .multstartE(multstartE), .multsignE(multsignE),
    .srcaE(srcaE), .srcbE(srcbE), .lohiM(lohiM), .multresM(multresM),
    .multbusy(multbusy), .multdone(multdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vecT;

  vecT         vecs [9];
  logic [63:0] sbQ [$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] lastHi = 32'd0;
  logic [31:0] lastLo = 32'd0;

  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    lohiM = 1'b1;
    #1 hi = multresM;
    lohiM = 1'b0;
    #1 lo = multresM;
  endtask

  // Called at a negedge: presents a start, returns at the negedge after edge 0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    srcaE = a; srcbE = b; multsignE = s; multstartE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    multstartE = 1'b0;
    check("busy_after_start", {63'd0, multbusy}, 64'd1);
  endtask

  // Waits for multdone, checks latency and the popped expected result.
  task automatic finishOp(input string name, input int startElapsed);
    int          elapsed;
    bit          seen;
    logic [31:0] hi, lo;
    logic [63:0] exp;
    elapsed = startElapsed;
    seen = 0;
    while (!seen && elapsed < 100) begin
      @(posedge clk);
      elapsed++;
      @(negedge clk);
      if (multdone) seen = 1;
    end
    exp = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hx;
    if (!seen) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, "_latency"}, 64'(elapsed), 64'(Lat));
      readHiLo(hi, lo);
      check({name, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
      check({name, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
      $display("op %s a=%h b=%h s=%0d hi=%h lo=%h", name, srcaE, srcbE, multsignE, hi, lo);
      lastHi = exp[63:32];
      lastLo = exp[31:0];
      @(posedge clk);
      @(negedge clk);
      check({name, "_done_pulse"}, {63'd0, multdone}, 64'd0);
      check({name, "_idle_after"}, {63'd0, multbusy}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] hi, lo, a, b;
    logic        s;
    int          stray;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    vecs[4] = '{32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'hFFFFFFFF};
    vecs[7] = '{32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000};
    vecs[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h3FFFFFFF, 32'h00000001};

    // Reset asserted together with a start request: reset wins.
    rst = 1'b0; multstartE = 1'b1; multsignE = 1'b0; lohiM = 1'b0;
    srcaE = 32'hFFFFFFFF; srcbE = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, multbusy}, 64'd0);
    check("reset_done", {63'd0, multdone}, 64'd0);
    readHiLo(hi, lo);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    multstartE = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", {63'd0, multbusy}, 64'd0);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      sbQ.push_back({vecs[i].hi, vecs[i].lo});
      launch(vecs[i].a, vecs[i].b, vecs[i].s);
      finishOp($sformatf("vec%0d", i), 0);
    end

    // A few random operands against the reference product.
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      sbQ.push_back(refMul(a, b, s));
      launch(a, b, s);
      finishOp($sformatf("rand%0d", i), 0);
    end

    // Start while busy is ignored; reads during busy return the old HI/LO.
    sbQ.push_back({32'h00000001, 32'h00000000});
    launch(32'h00010000, 32'h00010000, 1'b0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    srcaE = 32'd2; srcbE = 32'd3; multstartE = 1'b1;
    readHiLo(hi, lo);
    check("busy_read_hi", {32'd0, hi}, {32'd0, lastHi});
    check("busy_read_lo", {32'd0, lo}, {32'd0, lastLo});
    @(posedge clk);
    @(negedge clk);
    multstartE = 1'b0;
    check("busy_still", {63'd0, multbusy}, 64'd1);
    finishOp("busy_ignore", 5);
    stray = 0;
    repeat (Lat + 3) begin
      @(posedge clk); @(negedge clk);
      if (multbusy || multdone) stray++;
    end
    check("no_queued_op", 64'(stray), 64'd0);

    // Reset in the middle of an operation aborts it and clears HI/LO.
    launch(32'h80000000, 32'h00000002, 1'b0);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    multstartE = 1'b1;
    #1;
    check("midreset_busy", {63'd0, multbusy}, 64'd0);
    check("midreset_done", {63'd0, multdone}, 64'd0);
    readHiLo(hi, lo);
    check("midreset_hi", {32'd0, hi}, 64'd0);
    check("midreset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("midreset_hold", {63'd0, multbusy}, 64'd0);
    rst = 1'b1;
    sbQ.push_back({32'h00000001, 32'h00000000});
    launch(32'h80000000, 32'h00000002, 1'b0);
    finishOp("rerun", 0);

    // Back-to-back: start held high across the multdone cycle.
    sbQ.push_back(refMul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
    srcaE = 32'hFFFFFFFF; srcbE = 32'hFFFFFFFF; multsignE = 1'b0; multstartE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srcaE = 32'h7FFFFFFF; srcbE = 32'hFFFFFFFD; multsignE = 1'b1;
    for (int k = 1; k <= Lat + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == Lat) begin
        check("b2b_done", {63'd0, multdone}, 64'd1);
        check("b2b_gap", {63'd0, multbusy}, 64'd0);
        readHiLo(hi, lo);
        check("b2b_first", {hi, lo}, sbQ.pop_front());
        $display("op b2b_first hi=%h lo=%h", hi, lo);
      end else begin
        check($sformatf("b2b_busy_%0d", k), {63'd0, multbusy}, 64'd1);
      end
    end
    multstartE = 1'b0;
    sbQ.push_back(refMul(32'h7FFFFFFF, 32'hFFFFFFFD, 1'b1));
    finishOp("b2b_second", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
